cpu_alu_issue: RTL
==================

// Module: cpu_alu_issue
// PURPOSE
//  Operand-issue stage directly upstream of the ALU. Accepts one decoded ALU instruction per
//  cycle, reads its sources from an internal 32-entry register file and selects reg/imm for B.
//  A per-register busy scoreboard stalls read-after-write hazards; writeback data is bypassed
//  into same-cycle reads. Issues operation/mod/operands to the ALU through a one-entry output register.
// PARAMETERS
//  DATA_W   32  operand/register width (must be >= 5)
//  BYPASS   1   1: same-cycle writeback data forwarded to reads; 0: that case stalls one cycle
// PORTS
//  clk            in   1       clock, all state on rising edge
//  rst            in   1       synchronous, active-high reset
//  in_valid       in   1       decoded instruction present
//  in_ready       out  1       stage accepts instruction this cycle
//  in_operation   in   3       funct3-coded ALU op (ADD=000 SL=001 SLT=010 SLTU=011 XOR=100 SR=101 OR=110 AND=111)
//  in_mod         in   7       funct7 modifier (0000000 / 0100000)
//  in_rs1,in_rs2  in   5       source register indices
//  in_rd          in   5       destination index (0 = no writeback)
//  in_use_imm     in   1       1: operand B = in_imm, rs2 ignored
//  in_imm         in   DATA_W  sign-extended immediate
//  out_valid      out  1       ALU instruction held
//  out_ready      in   1       ALU/next stage consumes this cycle
//  out_operation  out  3       to ALU operation
//  out_mod        out  7       to ALU mod
//  out_operand_a  out  DATA_W  to ALU operand_a
//  out_operand_b  out  DATA_W  to ALU operand_b
//  out_rd         out  5       destination carried to writeback
//  wb_en          in   1       register write strobe
//  wb_rd          in   5       write index
//  wb_data        in   DATA_W  write data
//  flush          in   1       discard held and incoming instruction
// BEHAVIOUR
//  Reset: out_valid=0, out_* data=0, all registers=0, all busy bits=0. in_ready=0 while rst.
//  Regfile: x0 always reads 0; writes to x0 ignored. wb_en writes wb_data at clock edge.
//  Read of rs with wb_en && wb_rd==rs && rs!=0: BYPASS=1 -> wb_data used; BYPASS=0 -> stall.
//  Hazard: (rs1!=0 && busy[rs1]) || (!in_use_imm && rs2!=0 && busy[rs2]); a busy bit being
//   cleared by wb this cycle does not count as busy when BYPASS=1.
//  in_ready = !rst && !flush && !hazard && (!out_valid || out_ready). Accept = in_valid && in_ready.
//  Latency: accept at edge N -> out_valid=1 with captured values after edge N (one cycle).
//  Output register holds stable while out_valid && !out_ready; cleared (out_valid=0) when
//   consumed and nothing accepted.
//  Operand B: in_use_imm ? in_imm : rf[rs2]. If op is SL or SR, out_operand_b = {0, B[4:0]}.
//  Mod: if in_use_imm && op==ADD, out_mod forced 0000000 (no SUB-immediate); otherwise in_mod.
//   Mod values are not otherwise checked; ALU flags illegal combinations.
//  Scoreboard: accept with in_rd!=0 sets busy[in_rd]; wb_en clears busy[wb_rd]. Same rd set and
//   cleared in one cycle: set wins. Busy bits independent of out_valid.
//  flush: out_valid<=0, busy[out_rd] cleared if out_valid (unless wb same cycle sets/clears
//   others normally); no accept that cycle. wb writes still performed during flush.
//  Reset mid-operation: all state returns to reset values at that edge; wb ignored.
// TESTING
//  rst 2 cycles -> out_valid=0, in_ready=1 next cycle; read x5 returns 0.
//  wb x3=0x10; issue ADD rs1=x3 imm=-1 mod=0100000 -> operand_a=0x10, operand_b=0xFFFFFFFF, mod=0.
//  issue rd=x7 then op reading x7 -> in_ready=0 until wb_en x7=0x55; same cycle wb -> accepted, operand_a=0x55.
//  SR rs2=x4 (x4=0x123) mod=0100000 -> operand_b=0x3, mod=0100000 passed through.
//  out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0; release -> next issued.
//  flush with held rd=x9 -> out_valid=0 next cycle, busy[x9]=0, reader of x9 issues at once.

Source files
------------

// File: rtl/cpu_alu_issue_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_alu_issue_if
// Purpose  : Decode, writeback and ALU-issue signal bundle for cpu_alu_issue.
// Revision : 1.0 - initial release
// ============================================================================
interface cpu_alu_issue_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_operation;
  logic [6:0]        in_mod;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [4:0]        in_rd;
  logic              in_use_imm;
  logic [DATA_W-1:0] in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        out_operation;
  logic [6:0]        out_mod;
  logic [DATA_W-1:0] out_operand_a;
  logic [DATA_W-1:0] out_operand_b;
  logic [4:0]        out_rd;
  logic              wb_en;
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              flush;

  // Upstream/environment side
  modport master (
    output in_valid, in_operation, in_mod, in_rs1, in_rs2, in_rd, in_use_imm, in_imm,
    output out_ready, wb_en, wb_rd, wb_data, flush,
    input  in_ready, out_valid, out_operation, out_mod, out_operand_a, out_operand_b, out_rd
  );

  // Issue stage side
  modport slave (
    input  in_valid, in_operation, in_mod, in_rs1, in_rs2, in_rd, in_use_imm, in_imm,
    input  out_ready, wb_en, wb_rd, wb_data, flush,
    output in_ready, out_valid, out_operation, out_mod, out_operand_a, out_operand_b, out_rd
  );
endinterface
`default_nettype wire

// File: rtl/cpu_alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : cpu_alu_issue
// Purpose  : ALU operand-issue stage: regfile read, busy scoreboard, output reg.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_alu_issue #(
  parameter int DATA_W = 32,
  parameter bit BYPASS = 1'b1
) (
  input  wire logic     clk,
  input  wire logic     rst,
  cpu_alu_issue_if.slave bus
);
  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_SL  = 3'b001;
  localparam logic [2:0] c_OP_SR  = 3'b101;

  logic [DATA_W-1:0] r_rf [32];
  logic [31:0]       r_busy;
  logic              r_out_valid;
  logic [2:0]        r_out_op;
  logic [6:0]        r_out_mod;
  logic [DATA_W-1:0] r_out_a;
  logic [DATA_W-1:0] r_out_b;
  logic [4:0]        r_out_rd;

  logic              w_hit1, w_hit2;
  logic              w_stall1, w_stall2, w_hazard;
  logic [DATA_W-1:0] w_rs1_val, w_rs2_val, w_opb, w_opb_fin;
  logic              w_in_ready, w_accept;
  logic [6:0]        w_mod;
  logic [31:0]       w_busy_nxt;

  always_comb begin
    w_hit1 = bus.wb_en && (bus.wb_rd == bus.in_rs1) && (bus.in_rs1 != 5'd0);
    w_hit2 = bus.wb_en && (bus.wb_rd == bus.in_rs2) && (bus.in_rs2 != 5'd0);

    w_rs1_val = '0;
    if (bus.in_rs1 != 5'd0) w_rs1_val = (BYPASS && w_hit1) ? bus.wb_data : r_rf[bus.in_rs1];
    w_rs2_val = '0;
    if (bus.in_rs2 != 5'd0) w_rs2_val = (BYPASS && w_hit2) ? bus.wb_data : r_rf[bus.in_rs2];

    // Without bypass a same-cycle writeback is a hazard in its own right
    if (BYPASS) begin
      w_stall1 = (bus.in_rs1 != 5'd0) && r_busy[bus.in_rs1] && !w_hit1;
      w_stall2 = (bus.in_rs2 != 5'd0) && r_busy[bus.in_rs2] && !w_hit2;
    end else begin
      w_stall1 = (bus.in_rs1 != 5'd0) && (r_busy[bus.in_rs1] || w_hit1);
      w_stall2 = (bus.in_rs2 != 5'd0) && (r_busy[bus.in_rs2] || w_hit2);
    end
    w_hazard = w_stall1 || (!bus.in_use_imm && w_stall2);

    w_in_ready = !rst && !bus.flush && !w_hazard && (!r_out_valid || bus.out_ready);
    w_accept   = bus.in_valid && w_in_ready;

    w_opb     = bus.in_use_imm ? bus.in_imm : w_rs2_val;
    w_opb_fin = w_opb;
    if (bus.in_operation == c_OP_SL || bus.in_operation == c_OP_SR)
      w_opb_fin = {{(DATA_W-5){1'b0}}, w_opb[4:0]};

    // There is no subtract-immediate; ADDI always issues as a plain add
    w_mod = (bus.in_use_imm && bus.in_operation == c_OP_ADD) ? 7'd0 : bus.in_mod;

    w_busy_nxt = r_busy;
    if (bus.wb_en) w_busy_nxt[bus.wb_rd] = 1'b0;
    if (bus.flush && r_out_valid) w_busy_nxt[r_out_rd] = 1'b0;
    if (w_accept && bus.in_rd != 5'd0) w_busy_nxt[bus.in_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
      r_busy      <= '0;
      r_out_valid <= 1'b0;
      r_out_op    <= '0;
      r_out_mod   <= '0;
      r_out_a     <= '0;
      r_out_b     <= '0;
      r_out_rd    <= '0;
    end else begin
      if (bus.wb_en && bus.wb_rd != 5'd0) r_rf[bus.wb_rd] <= bus.wb_data;
      r_busy <= w_busy_nxt;
      if (bus.flush) begin
        r_out_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_op    <= bus.in_operation;
        r_out_mod   <= w_mod;
        r_out_a     <= w_rs1_val;
        r_out_b     <= w_opb_fin;
        r_out_rd    <= bus.in_rd;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_operation = r_out_op;
  assign bus.out_mod       = r_out_mod;
  assign bus.out_operand_a = r_out_a;
  assign bus.out_operand_b = r_out_b;
  assign bus.out_rd        = r_out_rd;
endmodule
`default_nettype wire
